// File: rtl/rotary_pkg.sv
// Shared definitions for the rotary value controller: FSM state encodings and
// the bit positions of the decoder event flags, packed as {push, ccw, cw}.
package rotary_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACK     = 2'd1,
        ST_PUBLISH = 2'd2
    } state_t;

    localparam int EVT_CW   = 0;
    localparam int EVT_CCW  = 1;
    localparam int EVT_PUSH = 2;
    localparam int EVT_W    = 3;

endpackage

// File: rtl/rotary_step_alu.sv
// Combinational step unit: moves a bounded value up or down by one step.
// Intermediate results use WIDTH+1 bits, so neither the sum nor the
// difference can overflow before the range check.
// Build option ROTARY_VALUE_CTRL_WRAP_EN: wrap around the range instead of
// saturating at its bounds.
module rotary_step_alu #(
    parameter int WIDTH   = 8,
    parameter int VAL_MIN = 0,
    parameter int VAL_MAX = 100
) (
    input  logic [WIDTH-1:0] value,
    input  logic [WIDTH-1:0] step,
    input  logic             dir,
    output logic [WIDTH-1:0] next_value
);

    localparam logic [WIDTH:0] MIN_X = (WIDTH+1)'(VAL_MIN);
    localparam logic [WIDTH:0] MAX_X = (WIDTH+1)'(VAL_MAX);
    localparam logic [WIDTH:0] ONE_X = (WIDTH+1)'(1);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    logic           below;

    // Next value for one step: dir=1 adds, dir=0 subtracts, then range fix-up.
    always_comb begin
        sum        = {1'b0, value} + {1'b0, step};
        diff       = {1'b0, value} - {1'b0, step};
        // A negative difference shows up as the extra top bit being set.
        below      = diff[WIDTH] || (diff < MIN_X);
        next_value = value;
        if (dir) begin
            if (sum > MAX_X) begin
`ifdef ROTARY_VALUE_CTRL_WRAP_EN
                next_value = WIDTH'(MIN_X + (sum - MAX_X - ONE_X));
`else
                next_value = WIDTH'(MAX_X);
`endif
            end else begin
                next_value = sum[WIDTH-1:0];
            end
        end else begin
            if (below) begin
`ifdef ROTARY_VALUE_CTRL_WRAP_EN
                next_value = WIDTH'(MAX_X - (MIN_X - diff - ONE_X));
`else
                next_value = WIDTH'(MIN_X);
`endif
            end else begin
                next_value = diff[WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/rotary_value_ctrl.sv
// Sequencer between the rotary quadrature decoder and the application.
// Consumes sticky cw/ccw/push flags, acknowledges them with rd_ack, keeps a
// bounded value with fine/coarse stepping and publishes every change over a
// valid/ready handshake. At most one event is in flight at a time.
// Build option ROTARY_VALUE_CTRL_WRAP_EN (in rotary_step_alu): wrap the value
// range instead of saturating.
module rotary_value_ctrl
    import rotary_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int VAL_MIN     = 0,
    parameter int VAL_MAX     = 100,
    parameter int VAL_INIT    = 50,
    parameter int STEP_FINE   = 1,
    parameter int STEP_COARSE = 10,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             evt_cw,
    input  logic             evt_ccw,
    input  logic             evt_push,
    output logic             rd_ack,
    output logic [WIDTH-1:0] value,
    output logic             coarse,
    output logic             val_valid,
    input  logic             val_ready,
    output logic             err
);

    localparam int               CNT_W   = $clog2(ACK_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [WIDTH-1:0] STEP_F  = WIDTH'(STEP_FINE);
    localparam logic [WIDTH-1:0] STEP_C  = WIDTH'(STEP_COARSE);

    state_t             state, state_n;
    logic [EVT_W-1:0]   evt;
    logic [WIDTH-1:0]   value_n, alu_next;
    logic               coarse_n, rd_ack_n, val_valid_n, err_n;
    logic               changed, changed_n;
    logic [CNT_W-1:0]   cnt, cnt_n;

    assign evt = {evt_push, evt_ccw, evt_cw};

    // The step uses the mode in force before any push in the same event.
    rotary_step_alu #(
        .WIDTH   (WIDTH),
        .VAL_MIN (VAL_MIN),
        .VAL_MAX (VAL_MAX)
    ) u_alu (
        .value      (value),
        .step       (coarse ? STEP_C : STEP_F),
        .dir        (evt[EVT_CW]),
        .next_value (alu_next)
    );

    // Register state and outputs; reset drops any event or publish in flight.
    always_ff @(posedge clk) begin
        if (!clr) begin
            state     <= ST_IDLE;
            value     <= WIDTH'(VAL_INIT);
            coarse    <= 1'b0;
            rd_ack    <= 1'b0;
            val_valid <= 1'b0;
            err       <= 1'b0;
            changed   <= 1'b0;
            cnt       <= '0;
        end else begin
            state     <= state_n;
            value     <= value_n;
            coarse    <= coarse_n;
            rd_ack    <= rd_ack_n;
            val_valid <= val_valid_n;
            err       <= err_n;
            changed   <= changed_n;
            cnt       <= cnt_n;
        end
    end

    // Next-state and next-output logic: sample events in IDLE, hold rd_ack
    // until the flags clear or the ack times out, then publish any change.
    always_comb begin
        state_n     = state;
        value_n     = value;
        coarse_n    = coarse;
        rd_ack_n    = rd_ack;
        val_valid_n = val_valid;
        err_n       = err;
        changed_n   = changed;
        cnt_n       = cnt;
        case (state)
            ST_IDLE: begin
                if (|evt) begin
                    if (evt[EVT_CW] ^ evt[EVT_CCW]) value_n = alu_next;
                    if (evt[EVT_CW] & evt[EVT_CCW]) err_n = 1'b1;
                    if (evt[EVT_PUSH]) coarse_n = ~coarse;
                    changed_n = (value_n != value) | evt[EVT_PUSH];
                    rd_ack_n  = 1'b1;
                    cnt_n     = '0;
                    state_n   = ST_ACK;
                end
            end
            ST_ACK: begin
                if (!(|evt) || cnt == CNT_END) begin
                    // Timeout only differs from a clean ack by raising err;
                    // a pending change is still published.
                    if (|evt) err_n = 1'b1;
                    rd_ack_n    = 1'b0;
                    cnt_n       = '0;
                    val_valid_n = changed;
                    state_n     = changed ? ST_PUBLISH : ST_IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_PUBLISH: begin
                if (val_ready) begin
                    val_valid_n = 1'b0;
                    state_n     = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

endmodule
